// File: rtl/swerv_types.sv
// Shared IFU/EXU types: BHT index geometry and the resolved-branch
// update packet that travels from EXU into the BHT update queue.
`ifndef RV_BHT_ADDR_HI
`define RV_BHT_ADDR_HI 8
`endif
`ifndef RV_BHT_ADDR_LO
`define RV_BHT_ADDR_LO 2
`endif

package swerv_types;

   localparam int BHT_ADDR_HI = `RV_BHT_ADDR_HI;
   localparam int BHT_ADDR_LO = `RV_BHT_ADDR_LO;
   localparam int BHT_IDX_W   = BHT_ADDR_HI - BHT_ADDR_LO + 1;
   localparam int BHT_ENTRIES = 2 ** BHT_IDX_W;

   typedef struct packed {
      logic [BHT_ADDR_HI:BHT_ADDR_LO] idx;
      logic [1:0]                     hist;
   } bht_upd_pkt_t;

endpackage

// File: rtl/ifu_bht_upd_fifo.sv
// BHT update queue. Ports: clk, rst (async high), push/din, pop/dout,
// full, empty, plus ent/vld: all slots in age order (0 = oldest).
module ifu_bht_upd_fifo
   import swerv_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  bht_upd_pkt_t             din,
   input  logic                     pop,
   output bht_upd_pkt_t             dout,
   output logic                     full,
   output logic                     empty,
   output bht_upd_pkt_t [DEPTH-1:0] ent,
   output logic [DEPTH-1:0]         vld
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   bht_upd_pkt_t mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] cnt;

   assign cnt   = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Payload needs no reset; the pointers define what is live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         ent[k] = mem[rd_ptr[AW-1:0] + AW'(k)];
         vld[k] = (PW'(k) < cnt);
      end
   end

endmodule

// File: rtl/ifu_bht_update_ctl.sv
// Queues resolved branch updates and drains them into the 2-bit BHT;
// serves 1-cycle lookups with bypass from incoming and queued updates.
// Ports: exu_upd_* (update in), ifu_rd_* (lookup), status counters.
module ifu_bht_update_ctl
   import swerv_types::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_upd_valid,
   input  logic [31:1] exu_upd_pc,
   input  logic [1:0]  exu_upd_hist,
   input  logic        exu_upd_ataken,
   input  logic        exu_upd_misp,
   input  logic        ifu_rd_en,
   input  logic [31:1] ifu_rd_pc,
   output logic        ifu_rd_valid,
   output logic [1:0]  ifu_rd_hist,
   output logic        upd_fifo_full,
   output logic [7:0]  upd_drop_cnt,
   output logic [15:0] misp_cnt
);

   logic [1:0] bht [BHT_ENTRIES];

   bht_upd_pkt_t                  upd_pkt;
   bht_upd_pkt_t                  head;
   bht_upd_pkt_t [FIFO_DEPTH-1:0] ent;
   logic [FIFO_DEPTH-1:0]         vld;
   logic [BHT_ADDR_HI:BHT_ADDR_LO] rd_idx;
   logic       empty;
   logic       push;
   logic       pop;
   logic       drop;
   logic [1:0] byp_hist;
   logic       unused;

   assign upd_pkt.idx  = exu_upd_pc[BHT_ADDR_HI:BHT_ADDR_LO];
   assign upd_pkt.hist = exu_upd_hist;
   assign rd_idx       = ifu_rd_pc[BHT_ADDR_HI:BHT_ADDR_LO];

   // Single-ported array: a lookup steals the port from the drain.
   assign pop  = !ifu_rd_en && !empty;
   assign push = exu_upd_valid && (!upd_fifo_full || pop);
   assign drop = exu_upd_valid && upd_fifo_full && !pop;

   assign unused = ^{exu_upd_ataken,
                     exu_upd_pc[31:BHT_ADDR_HI+1],
                     exu_upd_pc[BHT_ADDR_LO-1:1],
                     ifu_rd_pc[31:BHT_ADDR_HI+1],
                     ifu_rd_pc[BHT_ADDR_LO-1:1]};

   ifu_bht_upd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (upd_pkt),
      .pop   (pop),
      .dout  (head),
      .full  (upd_fifo_full),
      .empty (empty),
      .ent   (ent),
      .vld   (vld)
   );

   // Walk oldest to youngest so the youngest match wins; the
   // in-flight update (even one about to be dropped) beats the queue.
   always_comb begin
      byp_hist = bht[rd_idx];
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         if (vld[k] && ent[k].idx == rd_idx) byp_hist = ent[k].hist;
      end
      if (exu_upd_valid && upd_pkt.idx == rd_idx) byp_hist = exu_upd_hist;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b00;
      end else if (pop) begin
         bht[head.idx] <= head.hist;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifu_rd_valid <= 1'b0;
         ifu_rd_hist  <= 2'b00;
      end else begin
         ifu_rd_valid <= ifu_rd_en;
         if (ifu_rd_en) ifu_rd_hist <= byp_hist;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upd_drop_cnt <= '0;
         misp_cnt     <= '0;
      end else begin
         if (drop && upd_drop_cnt != 8'hFF)
            upd_drop_cnt <= upd_drop_cnt + 8'd1;
         if (push && exu_upd_misp && misp_cnt != 16'hFFFF)
            misp_cnt <= misp_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ifu_bht_update_ctl.sv
// Directed bench for ifu_bht_update_ctl: reset, drain, overflow/drop,
// queue and in-flight bypass, and reset with a loaded queue.
module tb_ifu_bht_update_ctl;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_upd_valid;
   logic [31:1] exu_upd_pc;
   logic [1:0]  exu_upd_hist;
   logic        exu_upd_ataken;
   logic        exu_upd_misp;
   logic        ifu_rd_en;
   logic [31:1] ifu_rd_pc;
   logic        ifu_rd_valid;
   logic [1:0]  ifu_rd_hist;
   logic        upd_fifo_full;
   logic [7:0]  upd_drop_cnt;
   logic [15:0] misp_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ifu_bht_update_ctl dut (
      .clk            (clk),
      .rst            (rst),
      .exu_upd_valid  (exu_upd_valid),
      .exu_upd_pc     (exu_upd_pc),
      .exu_upd_hist   (exu_upd_hist),
      .exu_upd_ataken (exu_upd_ataken),
      .exu_upd_misp   (exu_upd_misp),
      .ifu_rd_en      (ifu_rd_en),
      .ifu_rd_pc      (ifu_rd_pc),
      .ifu_rd_valid   (ifu_rd_valid),
      .ifu_rd_hist    (ifu_rd_hist),
      .upd_fifo_full  (upd_fifo_full),
      .upd_drop_cnt   (upd_drop_cnt),
      .misp_cnt       (misp_cnt)
   );

   task automatic check(input string tag, input int unsigned obs,
                        input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic v, input logic [31:0] pc,
                      input logic [1:0] h, input logic m);
      exu_upd_valid = v;
      exu_upd_pc    = pc[31:1];
      exu_upd_hist  = h;
      exu_upd_misp  = m;
   endtask

   task automatic rd(input logic en, input logic [31:0] pc);
      ifu_rd_en = en;
      ifu_rd_pc = pc[31:1];
   endtask

   initial begin
      rst = 1'b1;
      exu_upd_ataken = 1'b0;
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      rd(1'b0, 32'h0);
      step();
      step();
      check("rst_valid", ifu_rd_valid, 0);
      check("rst_hist", ifu_rd_hist, 0);
      check("rst_full", upd_fifo_full, 0);
      check("rst_drop", upd_drop_cnt, 0);
      check("rst_misp", misp_cnt, 0);
      rst = 1'b0;
      step();

      // Plain lookup of a cold entry.
      rd(1'b1, 32'h100);
      step();
      check("cold_valid", ifu_rd_valid, 1);
      check("cold_hist", ifu_rd_hist, 0);
      rd(1'b0, 32'h0);
      step();
      check("idle_valid", ifu_rd_valid, 0);

      // Update then drain, then read back from the array.
      upd(1'b1, 32'h104, 2'b11, 1'b1);
      step();
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      step();
      step();
      rd(1'b1, 32'h104);
      step();
      check("drain_hist", ifu_rd_hist, 3);
      check("drain_full", upd_fifo_full, 0);
      check("misp_one", misp_cnt, 1);

      // Reads block the drain; fill the queue, fifth update drops.
      rd(1'b1, 32'h0);
      upd(1'b1, 32'h4, 2'b01, 1'b0);
      step();
      upd(1'b1, 32'h8, 2'b10, 1'b0);
      step();
      rd(1'b1, 32'h4);
      upd(1'b1, 32'hC, 2'b11, 1'b0);
      step();
      check("q_byp_idx1", ifu_rd_hist, 1);
      rd(1'b1, 32'h0);
      upd(1'b1, 32'h10, 2'b01, 1'b0);
      step();
      check("fill_full", upd_fifo_full, 1);
      check("fill_nodrop", upd_drop_cnt, 0);
      rd(1'b1, 32'h14);
      upd(1'b1, 32'h14, 2'b10, 1'b0);
      step();
      check("drop_cnt", upd_drop_cnt, 1);
      check("drop_full", upd_fifo_full, 1);
      check("drop_byp", ifu_rd_hist, 2);
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      rd(1'b0, 32'h0);
      step();
      check("drain1_full", upd_fifo_full, 0);
      step();
      step();
      step();
      rd(1'b1, 32'h14);
      step();
      check("dropped_idx5", ifu_rd_hist, 0);
      rd(1'b1, 32'h10);
      step();
      check("arr_idx4", ifu_rd_hist, 1);
      rd(1'b1, 32'hC);
      step();
      check("arr_idx3", ifu_rd_hist, 3);

      // Two queued writes to idx 3; youngest must win over array.
      rd(1'b1, 32'h24);
      upd(1'b1, 32'hC, 2'b01, 1'b0);
      step();
      upd(1'b1, 32'hC, 2'b10, 1'b0);
      step();
      upd(1'b0, 32'h0, 2'b00, 1'b0);
      rd(1'b1, 32'hC);
      step();
      check("young_q", ifu_rd_hist, 2);

      // In-flight update to the looked-up index.
      upd(1'b1, 32'h1C, 2'b11, 1'b1);
      rd(1'b1, 32'h1C);
      step();
      check("inflight", ifu_rd_hist, 3);
      check("misp_two", misp_cnt, 2);
      upd(1'b0, 32'h0, 2'b00, 1'b0);

      // Three entries queued; asynchronous reset mid-cycle.
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", ifu_rd_valid, 0);
      check("arst_hist", ifu_rd_hist, 0);
      check("arst_full", upd_fifo_full, 0);
      check("arst_drop", upd_drop_cnt, 0);
      check("arst_misp", misp_cnt, 0);
      rst = 1'b0;
      rd(1'b1, 32'hC);
      step();
      check("arst_q3", ifu_rd_hist, 0);
      rd(1'b1, 32'h1C);
      step();
      check("arst_q7", ifu_rd_hist, 0);
      check("arst_rdv", ifu_rd_valid, 1);
      rd(1'b0, 32'h0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_bht_update_ctl.md
Name: ifu_bht_update_ctl

Overview:
Receiving end of the branch-resolution path. The EXU branch logic produces resolved branch packets: valid, PC, new 2-bit history, actual-taken and mispredict. This block queues those packets in a small FIFO and drains them into a 2-bit BHT counter array. It also serves one-cycle-latency prediction lookups from the IFU, with bypass from pending updates, so the IFU always sees the youngest resolved history.

Parameters:
BHT_ADDR_HI, 8, MSB of PC bits used as BHT index
BHT_ADDR_LO, 2, LSB of PC bits used as BHT index; entries = 2**(HI-LO+1) = 128
FIFO_DEPTH, 4, update queue depth; power of 2, >= 2

Ports:
clk  input  1  top-level clock
rst  input  1  asynchronous reset, active-high
exu_upd_valid  input  1  resolved branch update valid this cycle
exu_upd_pc  input  [31:1]  PC of resolved branch
exu_upd_hist  input  [1:0]  new 2-bit history computed by EXU
exu_upd_ataken  input  1  actual taken (status only, not stored in array)
exu_upd_misp  input  1  mispredict flag, counted only
ifu_rd_en  input  1  prediction lookup request
ifu_rd_pc  input  [31:1]  lookup PC
ifu_rd_valid  output  1  lookup result valid, one cycle after ifu_rd_en
ifu_rd_hist  output  [1:0]  history for the looked-up index
upd_fifo_full  output  1  queue holds FIFO_DEPTH entries
upd_drop_cnt  output  [7:0]  saturating count of dropped updates
misp_cnt  output  [15:0]  saturating count of accepted updates with misp=1

Behaviour:
- Reset (async, rst=1): all array entries 2'b00. FIFO empty (rd/wr pointers 0). ifu_rd_valid=0, ifu_rd_hist=0, upd_drop_cnt=0, misp_cnt=0, upd_fifo_full=0.
- Index: idx = pc[BHT_ADDR_HI:BHT_ADDR_LO]. Same slice for updates and lookups.
- Push: exu_upd_valid accepted when FIFO not full, or when full and a pop occurs in the same cycle. Entry = {idx, hist}.
- Accepted update with exu_upd_misp=1 increments misp_cnt, saturating at 16'hFFFF.
- Drop: exu_upd_valid while full with no pop in the same cycle. Entry discarded; upd_drop_cnt increments, saturating at 8'hFF.
- Pop/drain: the array is single-ported and reads have priority.
  - When ifu_rd_en=0 and FIFO non-empty: head entry is written to array[idx] at that clock edge and popped.
  - When ifu_rd_en=1: no drain that cycle.
- Lookup latency: ifu_rd_en at cycle N gives ifu_rd_valid=1 with ifu_rd_hist registered at edge N+1. ifu_rd_valid=0 otherwise; ifu_rd_hist holds its last value.
- Bypass priority for a lookup in cycle N (youngest wins):
  1. Incoming exu_upd_valid in cycle N with matching idx (even if it is dropped because the FIFO is full).
  2. Youngest valid FIFO entry with matching idx.
  3. array[idx].
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH. full = MSBs differ and LSBs equal; empty = pointers equal.
- Simultaneous push and pop on a non-empty FIFO: occupancy unchanged. Push into an empty FIFO is never drained in the same cycle; earliest write is the next cycle.
- exu_upd_ataken is not stored in the array; the port is reserved for future use.
- No flush input: updates are already architecturally resolved and are never cancelled.
- Reset mid-operation: queued updates are lost, the array clears, and any lookup result is invalidated.

Decomposition:
- Shared package swerv_types gains bht_upd_pkt_t = {idx[BHT_ADDR_HI:BHT_ADDR_LO], hist[1:0]}.
- BHT_ADDR_HI/LO defaults come from the existing global config defines.
- One sub-module, ifu_bht_upd_fifo: parameterized FIFO with push/pop/full/empty and a flat entry+valid view for the bypass compare.
- Top level owns the array, arbitration, bypass and counters.

Test Plan:
- Reset, then lookup pc=0x100 -> next cycle ifu_rd_valid=1, ifu_rd_hist=2'b00.
- Update pc=0x104 hist=2'b11 with ifu_rd_en=0 for 2 cycles, then lookup pc=0x104 -> hist=2'b11 read from the array; FIFO empty.
- Hold ifu_rd_en=1 continuously, issue 5 updates (idx 1..5) with FIFO_DEPTH=4 -> fifth dropped, upd_drop_cnt=1, upd_fifo_full=1. Release ifu_rd_en -> 4 drain cycles, then full=0.
- Queue idx=3 hist=01, then idx=3 hist=10 while reads block the drain; lookup idx=3 -> 2'b10 (youngest FIFO entry wins).
- Same-cycle update idx=7 hist=11 and lookup idx=7 -> next cycle ifu_rd_hist=2'b11 (incoming bypass).
- Assert rst with 3 queued entries -> FIFO empty, counters 0, lookup of a queued idx returns 2'b00.
